vr_tx_arbiter: RTL and testbench

VR_TX_ARBITER -- requirements
Module: vr_tx_arbiter

---
 rtl/vr_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vr_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_tx_arbiter.sv
// ---------------------------------------------------------------------------
// vr_tx_arbiter
//   Shares one UDP TX metadata+data path among NUM_SRCS transmit engines.
//   A message (one metadata word, then data beats through 'last') is sent
//   atomically. The source for each message is picked round-robin in IDLE,
//   and that source keeps the path until its last data beat is accepted.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   src_meta_val/info/rdy       per-source metadata channel
//   src_data_val/data/last/
//     padbytes/rdy              per-source data channel
//   arb_to_udp_meta_*           granted metadata towards UDP TX
//   udp_to_arb_meta_rdy         UDP TX metadata ready
//   arb_to_udp_data_*           granted data beat towards UDP TX
//   udp_to_arb_data_rdy         UDP TX data ready
//   arb_busy                    high while a message is in progress
//   arb_grant_id                current or most recently granted source
//   arb_msg_cnt                 per-source count of completed messages
//                               (present only with VR_TX_ARB_STATS_EN)
//
// Build option
//   VR_TX_ARB_STATS_EN : adds arb_msg_cnt, 32-bit saturating counters of
//                        last-beat handshakes per source.
// ---------------------------------------------------------------------------
module vr_tx_arbiter #(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES_W = $clog2(NOC_DATA_W/8),
  parameter int NUM_SRCS       = 4,
  parameter int SRC_ID_W       = $clog2(NUM_SRCS),
  parameter int UDP_INFO_W     = 64
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_SRCS-1:0]                        src_meta_val,
  input  logic [NUM_SRCS-1:0][UDP_INFO_W-1:0]        src_meta_info,
  output logic [NUM_SRCS-1:0]                        src_meta_rdy,
  input  logic [NUM_SRCS-1:0]                        src_data_val,
  input  logic [NUM_SRCS-1:0][NOC_DATA_W-1:0]        src_data,
  input  logic [NUM_SRCS-1:0]                        src_data_last,
  input  logic [NUM_SRCS-1:0][NOC_PADBYTES_W-1:0]    src_data_padbytes,
  output logic [NUM_SRCS-1:0]                        src_data_rdy,
  output logic                                       arb_to_udp_meta_val,
  output logic [UDP_INFO_W-1:0]                      arb_to_udp_meta_info,
  input  logic                                       udp_to_arb_meta_rdy,
  output logic                                       arb_to_udp_data_val,
  output logic [NOC_DATA_W-1:0]                      arb_to_udp_data,
  output logic                                       arb_to_udp_data_last,
  output logic [NOC_PADBYTES_W-1:0]                  arb_to_udp_data_padbytes,
  input  logic                                       udp_to_arb_data_rdy,
`ifdef VR_TX_ARB_STATS_EN
  output logic [NUM_SRCS-1:0][31:0]                  arb_msg_cnt,
`endif
  output logic                                       arb_busy,
  output logic [SRC_ID_W-1:0]                        arb_grant_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] META = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]          state_q,  state_d;
  logic [SRC_ID_W-1:0] grant_q,  grant_d;
  logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic                sel_found;
  logic [SRC_ID_W-1:0] sel_idx;
  logic [SRC_ID_W:0]   cand_sum;
  logic                msg_done;

  // Round-robin search: candidates rr_ptr, rr_ptr+1, ... wrapping at
  // NUM_SRCS. The sum never exceeds 2*NUM_SRCS-2, so one subtraction wraps.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a signal unassigned would infer a latch.
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    cand_sum  = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (SRC_ID_W+1)'(i);
      if (cand_sum >= (SRC_ID_W+1)'(NUM_SRCS))
        cand_sum = cand_sum - (SRC_ID_W+1)'(NUM_SRCS);
      if (!sel_found && src_meta_val[cand_sum[SRC_ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand_sum[SRC_ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d                  = state_q;
    grant_d                  = grant_q;
    rr_ptr_d                 = rr_ptr_q;
    msg_done                 = 1'b0;
    src_meta_rdy             = '0;
    src_data_rdy             = '0;
    arb_to_udp_meta_val      = 1'b0;
    arb_to_udp_meta_info     = '0;
    arb_to_udp_data_val      = 1'b0;
    arb_to_udp_data          = '0;
    arb_to_udp_data_last     = 1'b0;
    arb_to_udp_data_padbytes = '0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = META;
        end
      end
      META: begin
        arb_to_udp_meta_val     = src_meta_val[grant_q];
        arb_to_udp_meta_info    = src_meta_info[grant_q];
        src_meta_rdy[grant_q]   = udp_to_arb_meta_rdy;
        if (src_meta_val[grant_q] && udp_to_arb_meta_rdy)
          state_d = DATA;
      end
      DATA: begin
        arb_to_udp_data_val      = src_data_val[grant_q];
        arb_to_udp_data          = src_data[grant_q];
        arb_to_udp_data_last     = src_data_last[grant_q];
        arb_to_udp_data_padbytes = src_data_padbytes[grant_q];
        src_data_rdy[grant_q]    = udp_to_arb_data_rdy;
        if (src_data_val[grant_q] && udp_to_arb_data_rdy && src_data_last[grant_q]) begin
          msg_done = 1'b1;
          state_d  = IDLE;
          // Next search starts just past the source that finished.
          rr_ptr_d = (grant_q == SRC_ID_W'(NUM_SRCS-1)) ? '0 : grant_q + SRC_ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_busy     = (state_q != IDLE);
  assign arb_grant_id = grant_q;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef VR_TX_ARB_STATS_EN
  logic [NUM_SRCS-1:0][31:0] msg_cnt_q, msg_cnt_d;

  always_comb begin
    msg_cnt_d = msg_cnt_q;
    if (msg_done && (msg_cnt_q[grant_q] != 32'hFFFF_FFFF))
      msg_cnt_d[grant_q] = msg_cnt_q[grant_q] + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msg_cnt_q <= '0;
    else        msg_cnt_q <= msg_cnt_d;
  end

  assign arb_msg_cnt = msg_cnt_q;
`else
  // Statistics disabled: msg_done has no consumer in this build.
  logic unused_msg_done;
  assign unused_msg_done = msg_done;
`endif

endmodule

// File: tb/tb_vr_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vr_tx_arbiter
//   Directed bench for vr_tx_arbiter (NUM_SRCS=4, 32-bit data). Inputs are
//   driven right after the falling edge; outputs are sampled 1 time unit
//   later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_vr_tx_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int IW = 16;
  localparam int PW = $clog2(DW/8);
  localparam int SW = $clog2(NS);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NS-1:0]             src_meta_val;
  logic [NS-1:0][IW-1:0]     src_meta_info;
  logic [NS-1:0]             src_meta_rdy;
  logic [NS-1:0]             src_data_val;
  logic [NS-1:0][DW-1:0]     src_data;
  logic [NS-1:0]             src_data_last;
  logic [NS-1:0][PW-1:0]     src_data_padbytes;
  logic [NS-1:0]             src_data_rdy;
  logic                      arb_to_udp_meta_val;
  logic [IW-1:0]             arb_to_udp_meta_info;
  logic                      udp_to_arb_meta_rdy;
  logic                      arb_to_udp_data_val;
  logic [DW-1:0]             arb_to_udp_data;
  logic                      arb_to_udp_data_last;
  logic [PW-1:0]             arb_to_udp_data_padbytes;
  logic                      udp_to_arb_data_rdy;
  logic                      arb_busy;
  logic [SW-1:0]             arb_grant_id;
`ifdef VR_TX_ARB_STATS_EN
  logic [NS-1:0][31:0]       arb_msg_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int busy_cyc;

  always #5 clk = ~clk;

  vr_tx_arbiter #(
    .NOC_DATA_W (DW),
    .NUM_SRCS   (NS),
    .UDP_INFO_W (IW)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .src_meta_val             (src_meta_val),
    .src_meta_info            (src_meta_info),
    .src_meta_rdy             (src_meta_rdy),
    .src_data_val             (src_data_val),
    .src_data                 (src_data),
    .src_data_last            (src_data_last),
    .src_data_padbytes        (src_data_padbytes),
    .src_data_rdy             (src_data_rdy),
    .arb_to_udp_meta_val      (arb_to_udp_meta_val),
    .arb_to_udp_meta_info     (arb_to_udp_meta_info),
    .udp_to_arb_meta_rdy      (udp_to_arb_meta_rdy),
    .arb_to_udp_data_val      (arb_to_udp_data_val),
    .arb_to_udp_data          (arb_to_udp_data),
    .arb_to_udp_data_last     (arb_to_udp_data_last),
    .arb_to_udp_data_padbytes (arb_to_udp_data_padbytes),
    .udp_to_arb_data_rdy      (udp_to_arb_data_rdy),
`ifdef VR_TX_ARB_STATS_EN
    .arb_msg_cnt              (arb_msg_cnt),
`endif
    .arb_busy                 (arb_busy),
    .arb_grant_id             (arb_grant_id)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] info_of(input int s);
    return IW'(32'hA000 + s);
  endfunction

  function automatic logic [DW-1:0] beat_of(input int s, input int b);
    return 32'hD000_0000 | (s << 8) | b;
  endfunction

  function automatic logic [PW-1:0] pad_of(input int s, input int b, input int n);
    return (b == n-1) ? PW'(s) : '0;
  endfunction

  task automatic clear_inputs();
    src_meta_val        = '0;
    src_meta_info       = '0;
    src_data_val        = '0;
    src_data            = '0;
    src_data_last       = '0;
    src_data_padbytes   = '0;
    udp_to_arb_meta_rdy = 1'b0;
    udp_to_arb_data_rdy = 1'b0;
  endtask

  task automatic request(input int s);
    src_meta_val[s]  = 1'b1;
    src_meta_info[s] = info_of(s);
  endtask

  task automatic drive_beat(input int s, input int b, input int n);
    src_data_val[s]      = 1'b1;
    src_data[s]          = beat_of(s, b);
    src_data_last[s]     = (b == n-1);
    src_data_padbytes[s] = pad_of(s, b, n);
  endtask

  // Ends on a falling edge with rst_n released; the next rising edge is
  // the first one that arbitrates.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entry: mid-cycle in IDLE with src s requesting. Runs one message of n
  // beats; rdy_pat bit k is the data-ready level in the k-th DATA cycle.
  // Exit: mid-cycle in the IDLE bubble after the message.
  task automatic msg(input int s, input int n, input logic [15:0] rdy_pat, output int busy_n);
    logic [NS-1:0] onehot;
    int b;
    int cyc;
    onehot    = '0;
    onehot[s] = 1'b1;
    busy_n    = 0;
    check("idle_busy", arb_busy, 0);
    check("idle_meta_val", arb_to_udp_meta_val, 0);
    check("idle_meta_rdy", src_meta_rdy, 0);
    // Beat 0 is offered during META to confirm it is not taken early.
    drive_beat(s, 0, n);
    udp_to_arb_meta_rdy = 1'b1;
    udp_to_arb_data_rdy = 1'b1;
    @(negedge clk); #1;
    busy_n += int'(arb_busy);
    check("meta_grant", arb_grant_id, s);
    check("meta_val", arb_to_udp_meta_val, 1);
    check("meta_info", arb_to_udp_meta_info, info_of(s));
    check("meta_rdy", src_meta_rdy, onehot);
    check("meta_data_rdy", src_data_rdy, 0);
    check("meta_data_val", arb_to_udp_data_val, 0);
    @(negedge clk);
    src_meta_val[s] = 1'b0;
    b   = 0;
    cyc = 0;
    while (b < n && cyc < 16) begin
      udp_to_arb_data_rdy = rdy_pat[cyc];
      drive_beat(s, b, n);
      #1;
      busy_n += int'(arb_busy);
      check("data_val", arb_to_udp_data_val, 1);
      check("data", arb_to_udp_data, beat_of(s, b));
      check("data_last", arb_to_udp_data_last, (b == n-1));
      check("data_pad", arb_to_udp_data_padbytes, pad_of(s, b, n));
      check("data_rdy", src_data_rdy, udp_to_arb_data_rdy ? onehot : '0);
      if (udp_to_arb_data_rdy) b++;
      cyc++;
      @(negedge clk);
    end
    if (b < n) check("beat_budget", b, n);
    src_data_val  = '0;
    src_data_last = '0;
    #1;
    check("end_busy", arb_busy, 0);
    check("end_data_val", arb_to_udp_data_val, 0);
    check("end_grant_hold", arb_grant_id, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // A request during reset must not produce any handshake signals.
    request(1);
    udp_to_arb_meta_rdy = 1'b1;
    udp_to_arb_data_rdy = 1'b1;
    #12;
    check("rst_busy", arb_busy, 0);
    check("rst_grant", arb_grant_id, 0);
    check("rst_meta_val", arb_to_udp_meta_val, 0);
    check("rst_data_val", arb_to_udp_data_val, 0);
    check("rst_meta_rdy", src_meta_rdy, 0);
    check("rst_data_rdy", src_data_rdy, 0);

    // Single source, 3 beats, ready held high: busy for META + 3 beats.
    do_reset();
    request(2);
    #1;
    msg(2, 3, 16'hFFFF, busy_cyc);
    check("src2_busy_cycles", busy_cyc, 4);

    // Sources 0,1,3 together; 0 re-requests after its message, so the
    // rotation continues 1,3 before 0 is served again.
    do_reset();
    request(0); request(1); request(3);
    #1;
    msg(0, 1, 16'hFFFF, busy_cyc);
    check("rr0_busy_cycles", busy_cyc, 2);
    request(0);
    msg(1, 2, 16'hFFFF, busy_cyc);
    msg(3, 1, 16'hFFFF, busy_cyc);
    msg(0, 1, 16'hFFFF, busy_cyc);

    // Source 1, 4 beats, data ready alternating 1,0,1,0...; other sources
    // offer data throughout and must never see ready.
    src_data_val[0] = 1'b1;
    src_data_val[2] = 1'b1;
    src_data_val[3] = 1'b1;
    request(1);
    msg(1, 4, 16'h5555, busy_cyc);
    check("toggle_busy_cycles", busy_cyc, 8);

    // Source 3: metadata stall, then reset in the middle of DATA.
    request(3);
    drive_beat(3, 0, 4);
    udp_to_arb_meta_rdy = 1'b0;
    udp_to_arb_data_rdy = 1'b1;
    @(negedge clk); #1;
    check("meta_stall_val", arb_to_udp_meta_val, 1);
    check("meta_stall_rdy", src_meta_rdy, 0);
    @(negedge clk);
    udp_to_arb_meta_rdy = 1'b1;
    #1;
    check("meta_stall_hold_grant", arb_grant_id, 3);
    check("meta_stall_hold_val", arb_to_udp_meta_val, 1);
    @(negedge clk);
    src_meta_val[3]     = 1'b0;
    udp_to_arb_data_rdy = 1'b0;
    #1;
    check("mid_data_val", arb_to_udp_data_val, 1);
    check("mid_data", arb_to_udp_data, beat_of(3, 0));
    #2;
    rst_n = 1'b0;
    request(0);
    request(3);
    udp_to_arb_data_rdy = 1'b1;
    #1;
    check("async_rst_data_val", arb_to_udp_data_val, 0);
    check("async_rst_busy", arb_busy, 0);
    check("async_rst_data_rdy", src_data_rdy, 0);
    check("async_rst_meta_val", arb_to_udp_meta_val, 0);
    check("async_rst_grant", arb_grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    msg(0, 1, 16'hFFFF, busy_cyc);
    clear_inputs();

`ifdef VR_TX_ARB_STATS_EN
    do_reset();
    #1;
    for (int k = 0; k < 5; k++) begin
      request(1);
      msg(1, 1, 16'hFFFF, busy_cyc);
    end
    for (int k = 0; k < 2; k++) begin
      request(0);
      msg(0, 2, 16'hFFFF, busy_cyc);
    end
    @(negedge clk); #1;
    check("cnt_src0", arb_msg_cnt[0], 2);
    check("cnt_src1", arb_msg_cnt[1], 5);
    check("cnt_src2", arb_msg_cnt[2], 0);
    check("cnt_src3", arb_msg_cnt[3], 0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
